laser_scan_ctrl: RTL

LASER_SCAN_CTRL -- requirements
Module: laser_scan_ctrl

---
 rtl/laser_scan_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/laser_scan_ctrl.sv
// laser_scan_ctrl: sweeps candidate circle centres over a full 16x16 grid or a
// clipped local window. For every candidate it streams NPTS point indices to a
// shared in-circle datapath and counts the hits that datapath returns one cycle
// later. The candidate with the highest hit count is kept; a later candidate
// wins a tie.
module laser_scan_ctrl #(
    parameter int NPTS = 40,
    parameter int RAD  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       FULL,
    input  logic [3:0] CX,
    input  logic [3:0] CY,
    output logic [3:0] CAND_X,
    output logic [3:0] CAND_Y,
    output logic [5:0] PIDX,
    output logic       PVALID,
    input  logic       HIT,
    output logic [3:0] BEST_X,
    output logic [3:0] BEST_Y,
    output logic [5:0] BEST_CNT,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [5:0]        LAST_IDX = 6'(NPTS - 1);
    localparam logic signed [5:0] RAD_S    = 6'(RAD);
    localparam logic signed [5:0] GRID_MAX = 6'sd15;

    logic [2:0] state;
    logic [2:0] state_nxt;

    logic       full_r;
    logic [3:0] cx_r;
    logic [3:0] cy_r;

    logic [3:0] xlo;
    logic [3:0] xhi;
    logic [3:0] ylo;
    logic [3:0] yhi;

    logic [3:0] win_xlo;
    logic [3:0] win_xhi;
    logic [3:0] win_ylo;
    logic [3:0] win_yhi;

    logic       pv_d;
    logic [5:0] cnt;
    logic       last_cand;
    logic       last_idx;

    // Lower window edge, clamped at 0 (computed wide so no 4-bit wrap).
    function automatic logic [3:0] sat_lo(input logic [3:0] c);
        logic signed [5:0] d;
        d = $signed({2'b00, c}) - RAD_S;
        if (d < 0) begin
            return 4'd0;
        end
        return d[3:0];
    endfunction

    // Upper window edge, clamped at 15 (computed wide so no 4-bit wrap).
    function automatic logic [3:0] sat_hi(input logic [3:0] c);
        logic signed [5:0] s;
        s = $signed({2'b00, c}) + RAD_S;
        if (s > GRID_MAX) begin
            return 4'd15;
        end
        return s[3:0];
    endfunction

    assign PVALID    = (state == S_ISSUE);
    assign BUSY      = (state != S_IDLE);
    assign DONE      = (state == S_FINISH);
    assign last_cand = (CAND_X == xhi) && (CAND_Y == yhi);
    assign last_idx  = (PIDX == LAST_IDX);

    // Window bounds derived from the request latched in IDLE.
    always_comb begin
        win_xlo = 4'd0;
        win_xhi = 4'd15;
        win_ylo = 4'd0;
        win_yhi = 4'd15;
        if (!full_r) begin
            win_xlo = sat_lo(cx_r);
            win_xhi = sat_hi(cx_r);
            win_ylo = sat_lo(cy_r);
            win_yhi = sat_hi(cy_r);
        end
    end

    // Next-state selection for the scan sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (START) state_nxt = S_INIT;
            S_INIT:   state_nxt = S_ISSUE;
            S_ISSUE:  if (last_idx) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = last_cand ? S_FINISH : S_ISSUE;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the scan request only when a new scan is accepted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_r <= 1'b0;
            cx_r   <= 4'd0;
            cy_r   <= 4'd0;
        end else if (state == S_IDLE && START) begin
            full_r <= FULL;
            cx_r   <= CX;
            cy_r   <= CY;
        end
    end

    // Freeze the window bounds for the duration of the scan.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            xlo <= 4'd0;
            xhi <= 4'd0;
            ylo <= 4'd0;
            yhi <= 4'd0;
        end else if (state == S_INIT) begin
            xlo <= win_xlo;
            xhi <= win_xhi;
            ylo <= win_ylo;
            yhi <= win_yhi;
        end
    end

    // Candidate walk: x fastest, then y; held in IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CAND_X <= 4'd0;
            CAND_Y <= 4'd0;
        end else if (state == S_INIT) begin
            CAND_X <= win_xlo;
            CAND_Y <= win_ylo;
        end else if (state == S_UPDATE && !last_cand) begin
            if (CAND_X == xhi) begin
                CAND_X <= xlo;
                CAND_Y <= CAND_Y + 4'd1;
            end else begin
                CAND_X <= CAND_X + 4'd1;
            end
        end
    end

    // Point index sweep 0..NPTS-1 while issuing; parked at 0 otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PIDX <= 6'd0;
        end else if (state == S_ISSUE && !last_idx) begin
            PIDX <= PIDX + 6'd1;
        end else begin
            PIDX <= 6'd0;
        end
    end

    // Hit counter: HIT answers the index issued one cycle earlier, so it is
    // qualified by a delayed copy of PVALID.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pv_d <= 1'b0;
            cnt  <= 6'd0;
        end else begin
            pv_d <= PVALID;
            if (state == S_INIT || state == S_UPDATE) begin
                cnt <= 6'd0;
            end else if (pv_d && HIT) begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    // Best-candidate tracking; ">=" lets a later candidate take a tie.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            BEST_X   <= 4'd0;
            BEST_Y   <= 4'd0;
            BEST_CNT <= 6'd0;
        end else if (state == S_INIT) begin
            BEST_X   <= 4'd0;
            BEST_Y   <= 4'd0;
            BEST_CNT <= 6'd0;
        end else if (state == S_UPDATE && cnt >= BEST_CNT) begin
            BEST_X   <= CAND_X;
            BEST_Y   <= CAND_Y;
            BEST_CNT <= cnt;
        end
    end

endmodule
